oam_dma_ctrl: RTL

- Sequences the 160-byte OAM DMA copy triggered by a CPU write to register FF46.
- Source page is the written value. Bytes page*256+0..159 are read over the shared memory bus and written to OAM through a dedicated write port into the PPU's oam_data array.
- Drives the PPU's oam_dma qualifier and a CPU lockout during the transfer.
- Sits between the CPU register decode, the memory bus arbiter and the PPU.

---
 rtl/gb_pkg.sv | 24 ++
 rtl/oam_dma_ctrl_if.sv | 30 +++
 rtl/oam_dma_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/gb_pkg.sv
// Shared Game Boy definitions: DMA sequencer states, bus constants and the
// echo-page remap used to form source addresses.
package gb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } dma_state_e;

    localparam int          OAM_BYTES = 160;
    localparam logic [15:0] REG_DMA   = 16'hFF46;
    localparam logic [15:0] HRAM_LO   = 16'hFF80;
    localparam logic [15:0] HRAM_HI   = 16'hFFFE;
    localparam logic [7:0]  ECHO_BASE = 8'hE0;

    // Echo RAM mirrors work RAM 0x2000 lower.
    function automatic logic [7:0] remap_page(input logic [7:0] page, input logic [7:0] base);
        return (page >= base) ? page - 8'h20 : page;
    endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// Register-write, memory-bus and OAM-write signals of the OAM DMA sequencer.
// master = DMA controller side, slave = CPU decode / bus arbiter / PPU side.
interface oam_dma_ctrl_if;
    logic        reg_wr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        busy;
    logic        cpu_lockout;
    logic        done;

    modport master (
        input  reg_wr, reg_wdata, mem_gnt, mem_rvalid, mem_rdata,
        output reg_rdata, mem_req, mem_addr, oam_we, oam_addr, oam_wdata,
               busy, cpu_lockout, done
    );

    modport slave (
        output reg_wr, reg_wdata, mem_gnt, mem_rvalid, mem_rdata,
        input  reg_rdata, mem_req, mem_addr, oam_we, oam_addr, oam_wdata,
               busy, cpu_lockout, done
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: copies NUM_BYTES bytes from page*256 into OAM on an FF46 write.
// Define OAM_DMA_RESTART_EN to let an FF46 write during a transfer restart it.
module oam_dma_ctrl #(
    parameter int         NUM_BYTES   = gb_pkg::OAM_BYTES,
    parameter int         START_DELAY = 1,
    parameter logic [7:0] ECHO_BASE   = gb_pkg::ECHO_BASE
) (
    input  logic           clk,
    input  logic           resetn,
    oam_dma_ctrl_if.master bus
);
    import gb_pkg::*;

    localparam int               DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [7:0]       LAST_IDX = 8'(NUM_BYTES - 1);
    localparam dma_state_e       START_ST = (START_DELAY == 0) ? REQ : DELAY;
    localparam logic [DLY_W-1:0] DLY_LOAD = (START_DELAY > 0) ? DLY_W'(START_DELAY - 1) : '0;

    dma_state_e       state_q, state_d;
    logic [7:0]       page_q, page_d;
    logic [7:0]       idx_q, idx_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             discard_q, discard_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             oam_we_q, oam_we_d;
    logic [7:0]       oam_addr_q, oam_addr_d;
    logic [7:0]       oam_wdata_q, oam_wdata_d;
    logic             busy_q, busy_d;
    logic             lockout_q, lockout_d;
    logic             done_q, done_d;
    logic             restart;

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        idx_d       = idx_q;
        dly_d       = dly_q;
        discard_d   = discard_q;
        rdata_d     = bus.reg_wr ? bus.reg_wdata : rdata_q;
        oam_we_d    = 1'b0;
        oam_addr_d  = oam_addr_q;
        oam_wdata_d = oam_wdata_q;
        done_d      = 1'b0;
`ifdef OAM_DMA_RESTART_EN
        restart     = bus.reg_wr;
`else
        restart     = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.reg_wr) begin
                    page_d  = bus.reg_wdata;
                    idx_d   = '0;
                    dly_d   = DLY_LOAD;
                    state_d = START_ST;
                end
            end
            DELAY: begin
                if (restart) begin
                    page_d  = bus.reg_wdata;
                    idx_d   = '0;
                    dly_d   = DLY_LOAD;
                    state_d = START_ST;
                end else if (dly_q == '0) begin
                    state_d = REQ;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            REQ: begin
                if (restart) begin
                    page_d  = bus.reg_wdata;
                    idx_d   = '0;
                    dly_d   = DLY_LOAD;
                    state_d = START_ST;
                end else if (bus.mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid && idx_q == LAST_IDX) begin
                    // Completion wins over a coincident trigger; the trigger then starts afresh.
                    oam_we_d    = 1'b1;
                    oam_addr_d  = idx_q;
                    oam_wdata_d = bus.mem_rdata;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                    if (restart) begin
                        page_d  = bus.reg_wdata;
                        idx_d   = '0;
                        dly_d   = DLY_LOAD;
                        state_d = START_ST;
                    end
                end else if (restart) begin
                    page_d = bus.reg_wdata;
                    idx_d  = '0;
                    dly_d  = DLY_LOAD;
                    if (bus.mem_rvalid) begin
                        state_d = START_ST;
                    end else begin
                        discard_d = 1'b1;
                        state_d   = DRAIN;
                    end
                end else if (bus.mem_rvalid) begin
                    oam_we_d    = 1'b1;
                    oam_addr_d  = idx_q;
                    oam_wdata_d = bus.mem_rdata;
                    idx_d       = idx_q + 8'd1;
                    state_d     = REQ;
                end
            end
            DRAIN: begin
                if (restart) begin
                    page_d = bus.reg_wdata;
                    idx_d  = '0;
                end
                if (bus.mem_rvalid && discard_q) begin
                    discard_d = 1'b0;
                    dly_d     = DLY_LOAD;
                    state_d   = START_ST;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE);
        lockout_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            page_q      <= '0;
            idx_q       <= '0;
            dly_q       <= '0;
            discard_q   <= 1'b0;
            rdata_q     <= '0;
            oam_we_q    <= 1'b0;
            oam_addr_q  <= '0;
            oam_wdata_q <= '0;
            busy_q      <= 1'b0;
            lockout_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            idx_q       <= idx_d;
            dly_q       <= dly_d;
            discard_q   <= discard_d;
            rdata_q     <= rdata_d;
            oam_we_q    <= oam_we_d;
            oam_addr_q  <= oam_addr_d;
            oam_wdata_q <= oam_wdata_d;
            busy_q      <= busy_d;
            lockout_q   <= lockout_d;
            done_q      <= done_d;
        end
    end

    assign bus.reg_rdata   = rdata_q;
    assign bus.mem_req     = (state_q == REQ);
    assign bus.mem_addr    = {remap_page(page_q, ECHO_BASE), idx_q};
    assign bus.oam_we      = oam_we_q;
    assign bus.oam_addr    = oam_addr_q;
    assign bus.oam_wdata   = oam_wdata_q;
    assign bus.busy        = busy_q;
    assign bus.cpu_lockout = lockout_q;
    assign bus.done        = done_q;

endmodule
